// File: rtl/boom_mshr_line_buffer.sv
// Refill line buffer for the MSHR file: one cache-line slot per MSHR collects
// TileLink grant beats (write port), hands rows back during RPQ drain (read
// port, 1-cycle latency, full throughput) and tracks a per-slot beat mask so
// each MSHR can see when its line is complete.
//
// Optional build macro: LB_PARITY_EN adds one even-parity bit per row plus
// i_inject_parity_err / o_resp_parity_err.
//
// Ports:
//   clock, reset          clock; synchronous active-high reset
//   i_wr_valid/o_wr_ready write handshake; i_wr_id, i_wr_offset, i_wr_data
//   i_rd_valid/o_rd_ready read handshake; i_rd_id, i_rd_offset
//   o_resp_valid/_data    read response, one cycle after the accepted read
//   i_clr_valid, i_clr_id clear the beat mask of one slot
//   o_line_full           bit k = every row of slot k written since last clear
module boom_mshr_line_buffer #(
  parameter  int unsigned N_MSHRS  = 2,
  parameter  int unsigned ROW_BITS = 128,
  parameter  int unsigned N_BEATS  = 4,
  localparam int unsigned ID_W     = (N_MSHRS > 1) ? $clog2(N_MSHRS) : 1,
  localparam int unsigned OFF_W    = (N_BEATS > 1) ? $clog2(N_BEATS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_wr_valid,
  output logic                o_wr_ready,
  input  logic [ID_W-1:0]     i_wr_id,
  input  logic [OFF_W-1:0]    i_wr_offset,
  input  logic [ROW_BITS-1:0] i_wr_data,
  input  logic                i_rd_valid,
  output logic                o_rd_ready,
  input  logic [ID_W-1:0]     i_rd_id,
  input  logic [OFF_W-1:0]    i_rd_offset,
  output logic                o_resp_valid,
  output logic [ROW_BITS-1:0] o_resp_data,
  input  logic                i_clr_valid,
  input  logic [ID_W-1:0]     i_clr_id,
  output logic [N_MSHRS-1:0]  o_line_full
`ifdef LB_PARITY_EN
  ,
  input  logic                i_inject_parity_err,
  output logic                o_resp_parity_err
`endif
);

  localparam int unsigned ID_SPAN = 1 << ID_W;

  // Storage: the data array carries no reset, only the control state does.
  logic [ROW_BITS-1:0]              mem_q [N_MSHRS][N_BEATS];
`ifdef LB_PARITY_EN
  logic                             par_q [N_MSHRS][N_BEATS];
  logic                             parity_err_q;
`endif
  logic [N_MSHRS-1:0][N_BEATS-1:0]  mask_q;
  logic [N_MSHRS-1:0][N_BEATS-1:0]  mask_d;
  logic [N_MSHRS-1:0]               line_full_q;
  logic [N_MSHRS-1:0]               line_full_d;
  logic                             ready_q;
  logic                             resp_valid_q;
  logic [ROW_BITS-1:0]              resp_data_q;

  logic [ID_SPAN-1:0]               id_ok;
  logic                             wr_fire;
  logic                             rd_fire;
  logic                             rd_hit;
  logic                             clr_fire;

  // Id codes at or above N_MSHRS only exist in non-power-of-2 configurations.
  always_comb begin
    id_ok = '0;
    for (int unsigned k = 0; k < ID_SPAN; k++) begin
      id_ok[k] = (k < N_MSHRS);
    end
  end

  assign wr_fire  = i_wr_valid & ready_q & id_ok[i_wr_id];
  assign rd_fire  = i_rd_valid & ready_q;
  assign rd_hit   = rd_fire & id_ok[i_rd_id];
  assign clr_fire = i_clr_valid & id_ok[i_clr_id];

  // Beat-mask update: clear applies before a same-cycle write to the slot.
  always_comb begin
    mask_d      = mask_q;
    line_full_d = '0;
    if (clr_fire) begin
      mask_d[i_clr_id] = '0;
    end
    if (wr_fire) begin
      mask_d[i_wr_id][i_wr_offset] = 1'b1;
    end
    for (int unsigned k = 0; k < N_MSHRS; k++) begin
      line_full_d[k] = &mask_d[k];
    end
  end

  // Row storage; reads in the control block see pre-write contents.
  always_ff @(posedge clock) begin
    if (wr_fire) begin
      mem_q[i_wr_id][i_wr_offset] <= i_wr_data;
`ifdef LB_PARITY_EN
      par_q[i_wr_id][i_wr_offset] <= (^i_wr_data) ^ i_inject_parity_err;
`endif
    end
  end

  // Control state and registered read response.
  always_ff @(posedge clock) begin
    if (reset) begin
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      mask_q       <= '0;
      line_full_q  <= '0;
`ifdef LB_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      ready_q      <= 1'b1;
      resp_valid_q <= rd_fire;
      mask_q       <= mask_d;
      line_full_q  <= line_full_d;
      if (rd_fire) begin
        resp_data_q <= rd_hit ? mem_q[i_rd_id][i_rd_offset] : '0;
`ifdef LB_PARITY_EN
        parity_err_q <= rd_hit ?
          ((^mem_q[i_rd_id][i_rd_offset]) ^ par_q[i_rd_id][i_rd_offset]) : 1'b0;
`endif
      end
    end
  end

  assign o_wr_ready   = ready_q;
  assign o_rd_ready   = ready_q;
  assign o_resp_valid = resp_valid_q;
  assign o_resp_data  = resp_data_q;
  assign o_line_full  = line_full_q;
`ifdef LB_PARITY_EN
  assign o_resp_parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_boom_mshr_line_buffer.sv
// Directed, table-driven bench for boom_mshr_line_buffer (default 2x4x128).
module tb_boom_mshr_line_buffer;

  logic         clock;
  logic         reset;
  logic         i_wr_valid;
  logic         o_wr_ready;
  logic [0:0]   i_wr_id;
  logic [1:0]   i_wr_offset;
  logic [127:0] i_wr_data;
  logic         i_rd_valid;
  logic         o_rd_ready;
  logic [0:0]   i_rd_id;
  logic [1:0]   i_rd_offset;
  logic         o_resp_valid;
  logic [127:0] o_resp_data;
  logic         i_clr_valid;
  logic [0:0]   i_clr_id;
  logic [1:0]   o_line_full;
`ifdef LB_PARITY_EN
  logic         i_inject_parity_err;
  logic         o_resp_parity_err;
`endif

  boom_mshr_line_buffer dut (
    .clock        (clock),
    .reset        (reset),
    .i_wr_valid   (i_wr_valid),
    .o_wr_ready   (o_wr_ready),
    .i_wr_id      (i_wr_id),
    .i_wr_offset  (i_wr_offset),
    .i_wr_data    (i_wr_data),
    .i_rd_valid   (i_rd_valid),
    .o_rd_ready   (o_rd_ready),
    .i_rd_id      (i_rd_id),
    .i_rd_offset  (i_rd_offset),
    .o_resp_valid (o_resp_valid),
    .o_resp_data  (o_resp_data),
    .i_clr_valid  (i_clr_valid),
    .i_clr_id     (i_clr_id),
    .o_line_full  (o_line_full)
`ifdef LB_PARITY_EN
    ,
    .i_inject_parity_err (i_inject_parity_err),
    .o_resp_parity_err   (o_resp_parity_err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [127:0] Z  = 128'h0;
  localparam logic [127:0] D1 = {4{32'h11111111}};
  localparam logic [127:0] D2 = {4{32'h22222222}};
  localparam logic [127:0] D3 = {4{32'h33333333}};
  localparam logic [127:0] D4 = {4{32'h44444444}};
  localparam logic [127:0] A0 = {4{32'h0badf00d}};
  localparam logic [127:0] F5 = {4{32'h55555555}};
  localparam logic [127:0] A2 = {4{32'hc0ffee00}};
  localparam logic [127:0] A3 = {4{32'h600dcafe}};
  localparam logic [127:0] FA = {4{32'haaaaaaaa}};
  localparam logic [127:0] X3 = {4{32'h13572468}};

  typedef struct {
    logic         wv;
    logic [0:0]   wid;
    logic [1:0]   woff;
    logic [127:0] wd;
    logic         rv;
    logic [0:0]   rid;
    logic [1:0]   roff;
    logic         cv;
    logic [0:0]   cid;
    logic         e_rv;
    logic [127:0] e_rd;
    logic [1:0]   e_lf;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp;
  int   n_fail;

  task automatic add(input logic wv, input logic [0:0] wid, input logic [1:0] woff,
                     input logic [127:0] wd, input logic rv, input logic [0:0] rid,
                     input logic [1:0] roff, input logic cv, input logic [0:0] cid,
                     input logic e_rv, input logic [127:0] e_rd, input logic [1:0] e_lf);
    vec_t v;
    v.wv = wv; v.wid = wid; v.woff = woff; v.wd = wd;
    v.rv = rv; v.rid = rid; v.roff = roff;
    v.cv = cv; v.cid = cid;
    v.e_rv = e_rv; v.e_rd = e_rd; v.e_lf = e_lf;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_wr_valid = 1'b0; i_wr_id = 1'b0; i_wr_offset = 2'd0; i_wr_data = Z;
    i_rd_valid = 1'b0; i_rd_id = 1'b0; i_rd_offset = 2'd0;
    i_clr_valid = 1'b0; i_clr_id = 1'b0;
`ifdef LB_PARITY_EN
    i_inject_parity_err = 1'b0;
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    idle_inputs();
    reset = 1'b1;

    //  wv    wid   woff  wd  rv    rid   roff  cv    cid   e_rv  e_rd e_lf
    // Fill slot 1; full flag rises after the row-3 edge.
    add(1'b1, 1'b1, 2'd0, D1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, Z,  2'b00);
    add(1'b1, 1'b1, 2'd1, D2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, Z,  2'b00);
    add(1'b1, 1'b1, 2'd2, D3, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, Z,  2'b00);
    add(1'b1, 1'b1, 2'd3, D4, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, Z,  2'b10);
    add(1'b0, 1'b0, 2'd0, Z,  1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, D3, 2'b10);
    add(1'b0, 1'b0, 2'd0, Z,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, D3, 2'b10);
    // Back-to-back reads, no bubbles.
    add(1'b0, 1'b0, 2'd0, Z,  1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, D1, 2'b10);
    add(1'b0, 1'b0, 2'd0, Z,  1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, D2, 2'b10);
    add(1'b0, 1'b0, 2'd0, Z,  1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, D3, 2'b10);
    add(1'b0, 1'b0, 2'd0, Z,  1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, D4, 2'b10);
    add(1'b0, 1'b0, 2'd0, Z,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, D4, 2'b10);
    // Fill slot 0.
    add(1'b1, 1'b0, 2'd0, A0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, D4, 2'b10);
    add(1'b1, 1'b0, 2'd1, F5, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, D4, 2'b10);
    add(1'b1, 1'b0, 2'd2, A2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, D4, 2'b10);
    add(1'b1, 1'b0, 2'd3, A3, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, D4, 2'b11);
    // Same-row read and write: old data, then new data.
    add(1'b1, 1'b0, 2'd1, FA, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, F5, 2'b11);
    add(1'b0, 1'b0, 2'd0, Z,  1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, FA, 2'b11);
    // Clear + write slot 0 row 3: mask0 becomes 4'b1000.
    add(1'b1, 1'b0, 2'd3, X3, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, FA, 2'b10);
    add(1'b1, 1'b0, 2'd0, A0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, FA, 2'b10);
    add(1'b1, 1'b0, 2'd1, F5, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, FA, 2'b10);
    add(1'b1, 1'b0, 2'd2, A2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, FA, 2'b11);
    add(1'b0, 1'b0, 2'd0, Z,  1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1, X3, 2'b11);
    // Clear slot 1; its data survives.
    add(1'b0, 1'b0, 2'd0, Z,  1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 1'b1, D4, 2'b01);
    add(1'b0, 1'b0, 2'd0, Z,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, D4, 2'b01);

    // Reset behaviour.
    repeat (3) @(negedge clock);
    check("rst_wr_ready", 128'(o_wr_ready), 128'(1'b0));
    check("rst_rd_ready", 128'(o_rd_ready), 128'(1'b0));
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_wr_ready", 128'(o_wr_ready), 128'(1'b1));
    check("post_rst_rd_ready", 128'(o_rd_ready), 128'(1'b1));
    check("post_rst_resp_valid", 128'(o_resp_valid), 128'(1'b0));
    check("post_rst_resp_data", o_resp_data, Z);
    check("post_rst_line_full", 128'(o_line_full), 128'(2'b00));

    // Table vectors: drive on negedge, check after the following posedge.
    foreach (vecs[i]) begin
      i_wr_valid = vecs[i].wv; i_wr_id = vecs[i].wid; i_wr_offset = vecs[i].woff;
      i_wr_data = vecs[i].wd;
      i_rd_valid = vecs[i].rv; i_rd_id = vecs[i].rid; i_rd_offset = vecs[i].roff;
      i_clr_valid = vecs[i].cv; i_clr_id = vecs[i].cid;
      @(negedge clock);
      check($sformatf("vec%0d_resp_valid", i), 128'(o_resp_valid), 128'(vecs[i].e_rv));
      check($sformatf("vec%0d_resp_data", i), o_resp_data, vecs[i].e_rd);
      check($sformatf("vec%0d_line_full", i), 128'(o_line_full), 128'(vecs[i].e_lf));
    end
    idle_inputs();

    // Reset during a pending read: response dropped, masks cleared.
    i_rd_valid = 1'b1; i_rd_id = 1'b0; i_rd_offset = 2'd3;
    reset = 1'b1;
    @(negedge clock);
    check("midrst_resp_valid", 128'(o_resp_valid), 128'(1'b0));
    check("midrst_resp_data", o_resp_data, Z);
    check("midrst_line_full", 128'(o_line_full), 128'(2'b00));
    check("midrst_ready", 128'(o_wr_ready), 128'(1'b0));
    idle_inputs();
    reset = 1'b0;
    @(negedge clock);
    check("midrst_ready_back", 128'(o_rd_ready), 128'(1'b1));
    // Data array is not reset.
    i_rd_valid = 1'b1; i_rd_id = 1'b0; i_rd_offset = 2'd3;
    @(negedge clock);
    check("midrst_data_kept_valid", 128'(o_resp_valid), 128'(1'b1));
    check("midrst_data_kept", o_resp_data, X3);
    idle_inputs();
    // Masks restart from zero: slot 0 full only after all four beats.
    for (int r = 0; r < 4; r++) begin
      i_wr_valid = 1'b1; i_wr_id = 1'b0; i_wr_offset = 2'(r); i_wr_data = D2;
      @(negedge clock);
      check($sformatf("refill_beat%0d_line_full", r), 128'(o_line_full),
            (r == 3) ? 128'(2'b01) : 128'(2'b00));
    end
    idle_inputs();

`ifdef LB_PARITY_EN
    // Parity: injected error flagged, clean row not flagged.
    i_wr_valid = 1'b1; i_wr_id = 1'b1; i_wr_offset = 2'd0; i_wr_data = D1;
    i_inject_parity_err = 1'b1;
    @(negedge clock);
    idle_inputs();
    i_rd_valid = 1'b1; i_rd_id = 1'b1; i_rd_offset = 2'd0;
    @(negedge clock);
    check("par_inject_err", 128'(o_resp_parity_err), 128'(1'b1));
    idle_inputs();
    i_wr_valid = 1'b1; i_wr_id = 1'b1; i_wr_offset = 2'd1; i_wr_data = A3;
    @(negedge clock);
    idle_inputs();
    i_rd_valid = 1'b1; i_rd_id = 1'b1; i_rd_offset = 2'd1;
    @(negedge clock);
    check("par_clean_err", 128'(o_resp_parity_err), 128'(1'b0));
    check("par_clean_data", o_resp_data, A3);
    idle_inputs();
`endif

    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
